// File: rtl/spike_count_sink_if.sv
// Result stream from spike_count_sink toward the host/IO stage: one output count per beat.
// Plain valid/ready. Master drives valid/idx/cnt/last and slave drives ready.
interface spike_count_sink_if #(
    parameter int IDX_WIDTH = 3,
    parameter int CNT_WIDTH = 8
);
    logic                 res_valid;
    logic                 res_ready;
    logic [IDX_WIDTH-1:0] res_idx;
    logic [CNT_WIDTH-1:0] res_cnt;
    logic                 res_last;

    modport master (
        output res_valid,
        output res_idx,
        output res_cnt,
        output res_last,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_idx,
        input  res_cnt,
        input  res_last,
        output res_ready
    );
endinterface

// File: rtl/spike_count_sink.sv
// Per-output spike counter over WINDOW enabled cycles, snapshotted into a shadow bank drained one beat per output.
// Latency: first beat valid the cycle after the closing en cycle. Backpressure: drain stalls on res_ready, counting never stalls, a close during a busy drain is dropped (sticky overrun).
// SPIKE_COUNT_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module spike_count_sink #(
    parameter int NUM_OUT   = 8,
    parameter int WINDOW    = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               en,
    input  logic [NUM_OUT-1:0] spk,
    spike_count_sink_if.master res,
    output logic               window_done,
    output logic               overrun
);
    localparam int IDX_WIDTH = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int WC_WIDTH  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_OUT - 1);
    localparam logic [WC_WIDTH-1:0]  LAST_WC  = WC_WIDTH'(WINDOW - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt    [NUM_OUT];
    logic [CNT_WIDTH-1:0] shadow [NUM_OUT];
    logic [CNT_WIDTH-1:0] snap   [NUM_OUT];
    logic [WC_WIDTH-1:0]  wc;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 close, hs, last, load, ovr_set;

    function automatic logic [CNT_WIDTH-1:0] add_spk(input logic [CNT_WIDTH-1:0] c, input logic s);
`ifdef SPIKE_COUNT_SATURATE_EN
        return (s && (c != '1)) ? c + 1'b1 : c;
`else
        return c + CNT_WIDTH'(s);
`endif
    endfunction

    // Snapshot includes the closing cycle's spikes.
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) snap[i] = add_spk(cnt[i], spk[i]);
    end

    assign close = en && (wc == LAST_WC);
    assign last  = (idx_q == LAST_IDX);
    assign hs    = res.res_valid && res.res_ready;

    assign res.res_valid = (state_q == DRAIN);
    assign res.res_idx   = idx_q;
    assign res.res_cnt   = shadow[idx_q];
    assign res.res_last  = last;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        ovr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (close) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (hs) begin
                    if (last) state_d = IDLE;
                    else      idx_d   = idx_q + 1'b1;
                end
                // A close only lands if the final beat leaves in the same cycle.
                if (close) begin
                    if (hs && last) begin
                        load    = 1'b1;
                        idx_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
            wc          <= '0;
            window_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            window_done <= close;
            if (ovr_set) overrun <= 1'b1;
            if (load) begin
                for (int i = 0; i < NUM_OUT; i++) shadow[i] <= snap[i];
            end
            if (en) begin
                if (close) begin
                    wc <= '0;
                    for (int i = 0; i < NUM_OUT; i++) cnt[i] <= '0;
                end else begin
                    wc <= wc + 1'b1;
                    for (int i = 0; i < NUM_OUT; i++) cnt[i] <= snap[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_spike_count_sink.sv
// Directed bench for spike_count_sink (NUM_OUT=4, WINDOW=10, CNT_WIDTH=3) with a behavioural model and beat scoreboard.
module tb_spike_count_sink;
    localparam int NUM_OUT = 4;
    localparam int WINDOW  = 10;
    localparam int CW      = 3;

    typedef struct {
        logic [1:0]    idx;
        logic [CW-1:0] cnt;
        logic          last;
    } beat_t;

    logic         clk = 1'b0;
    logic         srst = 1'b1;
    logic         en = 1'b0;
    logic [3:0]   spk = 4'b0;
    logic         window_done, overrun;
    int           checks = 0;
    int           failures = 0;

    beat_t        exp_q[$];
    int           m_cnt[NUM_OUT];
    int           m_wc = 0;
    int           m_busy = 0;
    bit           m_ov = 1'b0;

    spike_count_sink_if #(.IDX_WIDTH(2), .CNT_WIDTH(CW)) rif ();

    spike_count_sink #(.NUM_OUT(NUM_OUT), .WINDOW(WINDOW), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .srst(srst),
        .en(en),
        .spk(spk),
        .res(rif.master),
        .window_done(window_done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int madd(input int c, input bit s);
`ifdef SPIKE_COUNT_SATURATE_EN
        return (c + s > 7) ? 7 : c + s;
`else
        return (c + s) % 8;
`endif
    endfunction

    // Scoreboard: each accepted beat is compared against the oldest expected beat.
    always @(negedge clk) begin
        if (!srst && rif.res_valid && rif.res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(rif.res_idx), 32'hFFFF_FFFF);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                chk("beat_idx", 32'(rif.res_idx), 32'(b.idx));
                chk("beat_cnt", 32'(rif.res_cnt), 32'(b.cnt));
                chk("beat_last", 32'(rif.res_last), 32'(b.last));
            end
        end
    end

    task automatic step(input bit rst, input bit e, input logic [3:0] s, input bit r);
        bit    close;
        bit    hs;
        int    snap[NUM_OUT];
        beat_t b;
        srst = rst;
        en = e;
        spk = s;
        rif.res_ready = r;
        close = 1'b0;
        hs = r && (m_busy > 0);
        if (rst) begin
            m_busy = 0;
            m_ov = 1'b0;
            m_wc = 0;
            for (int i = 0; i < NUM_OUT; i++) m_cnt[i] = 0;
            exp_q.delete();
        end else begin
            if (hs) m_busy--;
            if (e) begin
                for (int i = 0; i < NUM_OUT; i++) snap[i] = madd(m_cnt[i], s[i]);
                if (m_wc == WINDOW - 1) begin
                    close = 1'b1;
                    m_wc = 0;
                    for (int i = 0; i < NUM_OUT; i++) m_cnt[i] = 0;
                    if (m_busy == 0) begin
                        for (int i = 0; i < NUM_OUT; i++) begin
                            b.idx = 2'(i);
                            b.cnt = CW'(snap[i]);
                            b.last = (i == NUM_OUT - 1);
                            exp_q.push_back(b);
                        end
                        m_busy = NUM_OUT;
                    end else begin
                        m_ov = 1'b1;
                    end
                end else begin
                    m_wc++;
                    for (int i = 0; i < NUM_OUT; i++) m_cnt[i] = snap[i];
                end
            end
        end
        @(posedge clk);
        #1;
        chk("window_done", 32'(window_done), 32'(close));
        chk("overrun", 32'(overrun), 32'(m_ov));
        chk("res_valid", 32'(rif.res_valid), 32'(m_busy > 0));
        if (m_busy > 0) chk("res_idx", 32'(rif.res_idx), 32'(NUM_OUT - m_busy));
    endtask

    task automatic drain();
        for (int i = 0; i < NUM_OUT; i++) step(0, 0, 4'b0000, 1);
    endtask

    initial begin
        rif.res_ready = 1'b0;
        step(1, 0, 4'b0000, 0);
        step(1, 0, 4'b0000, 0);
        chk("reset_idx", 32'(rif.res_idx), 32'd0);

        // Sparse spikes on one output, consumer always ready.
        for (int i = 0; i < WINDOW; i++)
            step(0, 1, (i == 0 || i == 3 || i == 6) ? 4'b0010 : 4'b0000, 1);
        drain();

        // All outputs spike every cycle: saturate vs wrap boundary.
        for (int i = 0; i < WINDOW; i++) step(0, 1, 4'b1111, 1);
        drain();

        // en toggling: idle cycles neither count nor advance.
        for (int i = 0; i < 2 * WINDOW; i++) step(0, (i % 2) == 0, 4'b0001, 1);
        drain();

        // Stalled consumer across two windows: second snapshot dropped.
        for (int i = 0; i < 2 * WINDOW; i++) step(0, 1, (i < 3) ? 4'b0001 : 4'b0000, 0);
        drain();
        step(0, 0, 4'b0000, 1);

        // Reset in the middle of a drain and mid-window.
        for (int i = 0; i < WINDOW; i++) step(0, 1, 4'b0011, 0);
        step(0, 1, 4'b0011, 1);
        step(1, 1, 4'b1111, 0);
        chk("post_reset_idx", 32'(rif.res_idx), 32'd0);
        for (int i = 0; i < WINDOW; i++) step(0, 1, 4'b0101, 1);
        drain();

        // Last beat handshake coincides with the next window close.
        for (int i = 0; i < WINDOW; i++) step(0, 1, 4'b0100, 1);
        for (int i = 0; i < WINDOW; i++) step(0, 1, 4'b1000, i >= WINDOW - NUM_OUT);
        chk("coincide_idx", 32'(rif.res_idx), 32'd0);
        drain();
        step(0, 0, 4'b0000, 0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
